// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals around mem_port_arbiter.
// The arbiter takes the slave view; the requesters plus memory take the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              fetch_req_in;
    logic [ADDR_W-1:0] fetch_addr_in;
    logic              data_rd_req_in;
    logic              data_wr_req_in;
    logic [ADDR_W-1:0] data_addr_in;
    logic              mem_output_valid_in;
    logic              mem_write_ready_in;
    logic [ADDR_W-1:0] mem_addr_out;
    logic              mem_read_en_out;
    logic              mem_write_en_out;
    logic [1:0]        grant_out;
    logic              fetch_ack_out;
    logic              data_ack_out;
    logic              fetch_stall_out;
    logic              data_stall_out;
    logic              error_out;

    modport slave (
        input  fetch_req_in, fetch_addr_in, data_rd_req_in, data_wr_req_in, data_addr_in,
        input  mem_output_valid_in, mem_write_ready_in,
        output mem_addr_out, mem_read_en_out, mem_write_en_out, grant_out,
        output fetch_ack_out, data_ack_out, fetch_stall_out, data_stall_out, error_out
    );

    modport master (
        output fetch_req_in, fetch_addr_in, data_rd_req_in, data_wr_req_in, data_addr_in,
        output mem_output_valid_in, mem_write_ready_in,
        input  mem_addr_out, mem_read_en_out, mem_write_en_out, grant_out,
        input  fetch_ack_out, data_ack_out, fetch_stall_out, data_stall_out, error_out
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by instruction fetch and decoder load/store, one access at a time.
// Define MEM_ARB_TIMEOUT_EN to build the watchdog that aborts accesses after TIMEOUT_CYCLES.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);
    // Encoding doubles as the grant_out code.
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        FETCH_RD = 2'b01,
        DATA_RD  = 2'b10,
        DATA_WR  = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              fetch_ack_q, fetch_ack_d;
    logic              data_ack_q, data_ack_d;
    logic              last_grant_data_q, last_grant_data_d;
    logic              fetch_elig, data_elig;
    logic              done, timeout;

    // A requester still sitting in its ack cycle must not be granted again.
    assign fetch_elig = bus.fetch_req_in & ~fetch_ack_q;
    assign data_elig  = (bus.data_rd_req_in | bus.data_wr_req_in) & ~data_ack_q;
    assign done       = (state_q == DATA_WR) ? bus.mem_write_ready_in : bus.mem_output_valid_in;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             error_q;

    assign timeout = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            error_q <= 1'b0;
        end else begin
            cnt_q   <= (state_q == IDLE) ? '0 : cnt_q + 1'b1;
            error_q <= timeout & ~done;
        end
    end

    assign bus.error_out = error_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout            = 1'b0;
    assign bus.error_out      = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q           <= IDLE;
            addr_q            <= '0;
            fetch_ack_q       <= 1'b0;
            data_ack_q        <= 1'b0;
            last_grant_data_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            addr_q            <= addr_d;
            fetch_ack_q       <= fetch_ack_d;
            data_ack_q        <= data_ack_d;
            last_grant_data_q <= last_grant_data_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        fetch_ack_d       = 1'b0;
        data_ack_d        = 1'b0;
        last_grant_data_d = last_grant_data_q;
        case (state_q)
            IDLE: begin
                // Data has priority unless it won the previous contested grant.
                if (data_elig && (!fetch_elig || !last_grant_data_q)) begin
                    state_d           = bus.data_wr_req_in ? DATA_WR : DATA_RD;
                    addr_d            = bus.data_addr_in;
                    last_grant_data_d = 1'b1;
                end else if (fetch_elig) begin
                    state_d           = FETCH_RD;
                    addr_d            = bus.fetch_addr_in;
                    last_grant_data_d = 1'b0;
                end
            end
            default: begin
                if (done || timeout) begin
                    state_d = IDLE;
                    if (state_q == FETCH_RD) fetch_ack_d = 1'b1;
                    else                     data_ack_d  = 1'b1;
                end
            end
        endcase
    end

    assign bus.mem_addr_out     = addr_q;
    assign bus.grant_out        = state_q;
    assign bus.mem_read_en_out  = (state_q == FETCH_RD) || (state_q == DATA_RD);
    assign bus.mem_write_en_out = (state_q == DATA_WR);
    assign bus.fetch_ack_out    = fetch_ack_q;
    assign bus.data_ack_out     = data_ack_q;
    assign bus.fetch_stall_out  = bus.fetch_req_in & ~fetch_ack_q;
    assign bus.data_stall_out   = (bus.data_rd_req_in | bus.data_wr_req_in) & ~data_ack_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level owner/ack model.
// Compile with MEM_ARB_TIMEOUT_EN to exercise the watchdog (TIMEOUT_CYCLES=4 here).
module tb_mem_port_arbiter;
    localparam int ADDR_W = 32;
    localparam int TO     = 4;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus();
    mem_port_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    endtask

    // Model: who owns the port (0 none, 1 fetch, 2 load, 3 store) and the pending acks.
    int                m_owner;
    logic [ADDR_W-1:0] m_addr;
    bit                m_fack, m_dack, m_err, m_last_data;
    int                m_busy;
    int                err_seen = 0;

    task automatic model_reset();
        m_owner = 0; m_addr = '0; m_fack = 0; m_dack = 0; m_err = 0; m_last_data = 0; m_busy = 0;
    endtask

    task automatic model_step();
        bit f_el, d_el, fin, timed;
        f_el = bus.fetch_req_in && !m_fack;
        d_el = (bus.data_rd_req_in || bus.data_wr_req_in) && !m_dack;
        m_fack = 0; m_dack = 0; m_err = 0;
        if (m_owner == 0) begin
            if (d_el && (!f_el || !m_last_data)) begin
                m_owner = bus.data_wr_req_in ? 3 : 2;
                m_addr = bus.data_addr_in; m_last_data = 1; m_busy = 0;
            end else if (f_el) begin
                m_owner = 1; m_addr = bus.fetch_addr_in; m_last_data = 0; m_busy = 0;
            end
        end else begin
            fin   = (m_owner == 3) ? bus.mem_write_ready_in : bus.mem_output_valid_in;
            timed = TO_ON && (m_busy + 1 >= TO);
            if (fin || timed) begin
                if (m_owner == 1) m_fack = 1; else m_dack = 1;
                m_err = !fin;
                m_owner = 0;
            end else m_busy++;
        end
    endtask

    task automatic compare_all();
        logic [1:0] g;
        g = m_owner[1:0];
        chk("grant", bus.grant_out, g);
        chk("addr", bus.mem_addr_out, m_addr);
        chk("read_en", bus.mem_read_en_out, (m_owner == 1 || m_owner == 2));
        chk("write_en", bus.mem_write_en_out, (m_owner == 3));
        chk("fetch_ack", bus.fetch_ack_out, m_fack);
        chk("data_ack", bus.data_ack_out, m_dack);
        chk("fetch_stall", bus.fetch_stall_out, bus.fetch_req_in && !m_fack);
        chk("data_stall", bus.data_stall_out, (bus.data_rd_req_in || bus.data_wr_req_in) && !m_dack);
        chk("error", bus.error_out, m_err);
        if (bus.error_out) err_seen++;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset) model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive_reqs();
        int r;
        if (!bus.fetch_req_in) begin
            if ($urandom_range(0, 2) == 0) begin
                bus.fetch_req_in = 1'b1; bus.fetch_addr_in = $urandom & ~32'h3;
            end
        end else if (m_fack) begin
            if ($urandom_range(0, 1) == 1) bus.fetch_req_in = 1'b0;
        end else if (m_owner == 1 && $urandom_range(0, 19) == 0) bus.fetch_req_in = 1'b0;

        if (!(bus.data_rd_req_in || bus.data_wr_req_in)) begin
            if ($urandom_range(0, 2) == 0) begin
                r = $urandom_range(0, 9);
                bus.data_rd_req_in = (r < 5) || (r == 9);
                bus.data_wr_req_in = (r >= 5);
                bus.data_addr_in   = $urandom;
            end
        end else if (m_dack) begin
            if ($urandom_range(0, 1) == 1) begin
                bus.data_rd_req_in = 1'b0; bus.data_wr_req_in = 1'b0;
            end
        end else if (m_owner >= 2 && $urandom_range(0, 19) == 0) begin
            bus.data_rd_req_in = 1'b0; bus.data_wr_req_in = 1'b0;
        end
    endtask

    initial begin
        bus.fetch_req_in = 0; bus.fetch_addr_in = '0;
        bus.data_rd_req_in = 0; bus.data_wr_req_in = 0; bus.data_addr_in = '0;
        bus.mem_output_valid_in = 0; bus.mem_write_ready_in = 0;
        model_reset();
        @(negedge clk); @(negedge clk);
        compare_all();
        reset = 1'b1;

        // Simultaneous fetch and illegal rd+wr from reset: store wins, write takes precedence.
        bus.fetch_req_in = 1; bus.fetch_addr_in = 32'h100;
        bus.data_rd_req_in = 1; bus.data_wr_req_in = 1; bus.data_addr_in = 32'h8;
        cycle();
        chk("illegal_wr_grant", bus.grant_out, 2'b11);
        chk("illegal_rd_off", bus.mem_read_en_out, 1'b0);
        bus.mem_write_ready_in = 1;
        cycle();
        bus.mem_write_ready_in = 0;
        cycle();
        chk("fetch_after_store", bus.grant_out, 2'b01);

        for (int i = 0; i < 3000; i++) begin
            drive_reqs();
            bus.mem_output_valid_in = ($urandom_range(0, 2) == 0);
            bus.mem_write_ready_in  = ($urandom_range(0, 2) == 0);
            if (m_owner != 0 && $urandom_range(0, 99) == 0) begin
                reset = 1'b0;
                #1;
                model_reset();
                compare_all();
                cycle();
                reset = 1'b1;
            end
            cycle();
        end

        // Memory goes silent: without the watchdog the port stays owned.
        bus.fetch_req_in = 1; bus.fetch_addr_in = 32'h200;
        bus.mem_output_valid_in = 0; bus.mem_write_ready_in = 0;
        err_seen = 0;
        for (int i = 0; i < 110; i++) begin
            if (m_dack) begin bus.data_rd_req_in = 0; bus.data_wr_req_in = 0; end
            cycle();
        end
        if (TO_ON) chk("timeout_seen", (err_seen > 0), 1'b1);
        else       chk("hang_busy", (bus.grant_out != 2'b00), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port between the instruction-fetch requester and the decoder's data load/store requester.
- Grants one transaction at a time and drives the memory address and enables.
- Holds each requester in stall until its access completes, then returns a one-cycle acknowledge.
- Sits between the fetch/decoder stages and the memory interface, alongside the existing controller.

Parameters:
ADDR_W, 32, width of all address buses
TIMEOUT_CYCLES, 64, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
fetch_req_in  input  1  fetch read request; held high until fetch_ack_out
fetch_addr_in  input  ADDR_W  fetch address; stable while fetch_req_in is high
data_rd_req_in  input  1  decoder load request; held until data_ack_out
data_wr_req_in  input  1  decoder store request; held until data_ack_out
data_addr_in  input  ADDR_W  load/store address; stable while request is high
mem_output_valid_in  input  1  memory read data valid
mem_write_ready_in  input  1  memory write accepted
mem_addr_out  output  ADDR_W  registered address to memory
mem_read_en_out  output  1  read enable
mem_write_en_out  output  1  write enable
grant_out  output  2  00 none, 01 fetch, 10 data read, 11 data write
fetch_ack_out  output  1  one-cycle completion pulse for fetch
data_ack_out  output  1  one-cycle completion pulse for load/store
fetch_stall_out  output  1  fetch_req_in & ~fetch_ack_out
data_stall_out  output  1  (data_rd_req_in | data_wr_req_in) & ~data_ack_out
error_out  output  1  timeout flag (optional feature only; otherwise tied 0)

Behaviour:
- State machine: IDLE, FETCH_RD, DATA_RD, DATA_WR.
- Reset (reset=0, asynchronous):
  - state IDLE.
  - mem_addr_out 0; read and write enables 0.
  - grant_out 00; both acks 0; error_out 0.
  - last_grant_data flag 0.
  - Reset mid-transaction drops enables immediately; no ack is issued for the aborted access.
- IDLE eligibility: a requester is eligible only if its request is high and its ack_out is low this cycle. This prevents a duplicate grant during the ack cycle.
- IDLE arbitration, evaluated at each edge:
  - Data eligible, fetch not eligible: data wins.
  - Fetch eligible, data not eligible: fetch wins.
  - Both eligible: data wins unless last_grant_data=1, in which case fetch wins (alternating fairness).
  - last_grant_data is updated on every grant.
- Data request type: data_wr_req_in and data_rd_req_in both high is illegal; write takes precedence.
- On grant at edge k:
  - Next state is entered and mem_addr_out is loaded with the winner's address.
  - The matching enable and grant_out are high from edge k onward.
- FETCH_RD / DATA_RD:
  - mem_read_en_out is held high until mem_output_valid_in is sampled high at edge m.
  - At edge m: state returns to IDLE, enable drops, grant_out goes to 00, and the matching ack is high for exactly the cycle m..m+1.
- DATA_WR: same as the read states, with mem_write_en_out and mem_write_ready_in.
- Valid/ready seen while in IDLE is ignored.
- Latency: minimum 3 edges from request to ack (grant edge, completion edge, ack cycle). The earliest regrant of the same requester is the edge ending its ack cycle plus one.
- A request withdrawn mid-transaction has no effect; the transaction completes and the ack is still pulsed.
- Stalls are combinational from request and ack.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- When defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on grant and increments each cycle in a non-IDLE state.
  - On reaching TIMEOUT_CYCLES without valid/ready, the FSM returns to IDLE, drops enables, pulses the requester's ack with error_out high for that same cycle, and clears last_grant_data handling normally.
- When undefined:
  - No counter is built.
  - error_out is constant 0.
  - The FSM waits indefinitely.

Test Plan:
- Fetch only: fetch_req_in=1, addr 0x100; valid high 2 cycles after grant -> grant_out=01, mem_addr_out=0x100, read_en high 3 cycles, fetch_ack_out single pulse, fetch_stall_out low only in ack cycle.
- Load only: data_rd_req_in=1, addr 0x40, valid after 1 cycle -> grant_out=10, one data_ack_out pulse, no second grant while req held through ack.
- Simultaneous fetch and store from reset -> store granted first (11, write_en); after write_ready, fetch granted (01); next simultaneous pair grants data again.
- Reset low while in DATA_WR -> enables and grant_out 0 within the same cycle, no ack; after release, still-held request is regranted.
- Illegal rd+wr both high, addr 0x8 -> grant_out=11, mem_write_en_out=1, mem_read_en_out=0.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, fetch with no valid -> after 4 cycles fetch_ack_out=1 and error_out=1 together for one cycle, state IDLE; without macro, still waiting after 100 cycles.
